// File: rtl/load_buffer_pkg.sv
// Shared types for the load buffer: queued entry layout, FSM state encoding
// and memory access size codes.
package load_buffer_pkg;

    // Widest ROB tag an entry can carry; the top truncates to ROB_TAG_W.
    localparam int LB_TAG_MAX_W = 8;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [1:0] {
        LB_IDLE  = 2'd0,
        LB_WAIT  = 2'd1,
        LB_DRAIN = 2'd2
    } lb_state_e;

    typedef struct packed {
        logic [31:0]             addr;
        logic [LB_TAG_MAX_W-1:0] rob_tag;
        logic [1:0]              size;
        logic                    is_unsigned;
    } lb_entry_t;

endpackage

// File: rtl/load_buffer_align.sv
// Picks a byte/half/word out of a returned doubleword and sign- or
// zero-extends it to 32 bits.
module load_data_align
    import load_buffer_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    logic [31:0] low;

    assign low = 32'(data >> {offset, 3'b000});

    always_comb begin
        value = '0;
        case (size)
            MEM_BYTE: value = {{24{~is_unsigned & low[7]}}, low[7:0]};
            MEM_HALF: value = {{16{~is_unsigned & low[15]}}, low[15:0]};
            default:  value = low;
        endcase
    end

endmodule

// File: rtl/load_buffer.sv
// In-order load buffer: circular FIFO of pending loads, one outstanding
// memory read at a time, result held in a single writeback register.
//
// state    | meaning
// LB_IDLE  | no read outstanding; issues head entry when allowed
// LB_WAIT  | read for head entry outstanding; result loads writeback reg
// LB_DRAIN | flushed while a read was outstanding; discard its return
module load_buffer
    import load_buffer_pkg::*;
#(
    parameter int LB_SIZE   = 4,
    parameter int ROB_TAG_W = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       lb_push,
    input  logic [31:0]                in_addr,
    input  logic [ROB_TAG_W-1:0]       in_rob_tag,
    input  logic [1:0]                 in_size,
    input  logic                       in_unsigned,
    input  logic                       flush,
    input  logic                       lb_exec_stall,
    input  logic                       mem_data_valid,
    input  logic [63:0]                mem_data,
    input  logic                       lb_wr_written,
    output logic                       lb_read_mem,
    output logic [31:0]                lb_mem_addr,
    output logic                       lb_full,
    output logic [$clog2(LB_SIZE):0]   lb_count,
    output logic                       lb_wr_valid,
    output logic [31:0]                lb_wr_value,
    output logic [ROB_TAG_W-1:0]       lb_wr_rob_tag
);

    localparam int PTR_W = $clog2(LB_SIZE);
    localparam int CNT_W = PTR_W + 1;

    lb_entry_t        entries [LB_SIZE];
    lb_entry_t        head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    lb_state_e        state;
    lb_state_e        state_nxt;
    logic             push_ok;
    logic             issue;
    logic             pop;
    logic [31:0]      aligned;
    logic             tag_unused;

    assign head_entry = entries[head];
    assign lb_count   = count;
    assign lb_full    = (count == CNT_W'(LB_SIZE));

    assign push_ok = lb_push & ~lb_full & ~flush;
    assign issue   = (state == LB_IDLE) && (count != '0) && !lb_exec_stall && !flush;
    assign pop     = (state == LB_WAIT) && mem_data_valid && !flush;

    assign lb_read_mem = issue;
    assign lb_mem_addr = issue ? {head_entry.addr[31:3], 3'b000} : '0;

    // Tag bits above ROB_TAG_W are never driven by a real push.
    assign tag_unused = ^head_entry.rob_tag;

    load_data_align u_align (
        .data        (mem_data),
        .offset      (head_entry.addr[2:0]),
        .size        (head_entry.size),
        .is_unsigned (head_entry.is_unsigned),
        .value       (aligned)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            LB_IDLE:  if (issue) state_nxt = LB_WAIT;
            LB_WAIT: begin
                if (mem_data_valid) state_nxt = LB_IDLE;
                else if (flush)     state_nxt = LB_DRAIN;
            end
            LB_DRAIN: if (mem_data_valid) state_nxt = LB_IDLE;
            default:  state_nxt = LB_IDLE;
        endcase
    end

    // Entry storage needs no reset: occupancy is tracked by head/tail/count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            entries[tail] <= '{addr:        in_addr,
                               rob_tag:     LB_TAG_MAX_W'(in_rob_tag),
                               size:        in_size,
                               is_unsigned: in_unsigned};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LB_IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push_ok) tail <= tail + 1'b1;
                if (pop)     head <= head + 1'b1;
                count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lb_wr_valid   <= 1'b0;
            lb_wr_value   <= '0;
            lb_wr_rob_tag <= '0;
        end else if (flush) begin
            lb_wr_valid <= 1'b0;
        end else if (pop) begin
            lb_wr_valid   <= 1'b1;
            lb_wr_value   <= aligned;
            lb_wr_rob_tag <= head_entry.rob_tag[ROB_TAG_W-1:0];
        end else if (lb_wr_written) begin
            lb_wr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: vector table plus scoreboard-driven
// multi-cycle sequences (stall/full, flush, hold, reset mid-read).
module tb_load_buffer;
    import load_buffer_pkg::*;

    localparam int LB_SIZE   = 4;
    localparam int ROB_TAG_W = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 lb_push;
    logic [31:0]          in_addr;
    logic [ROB_TAG_W-1:0] in_rob_tag;
    logic [1:0]           in_size;
    logic                 in_unsigned;
    logic                 flush;
    logic                 lb_exec_stall;
    logic                 mem_data_valid;
    logic [63:0]          mem_data;
    logic                 lb_wr_written;
    logic                 lb_read_mem;
    logic [31:0]          lb_mem_addr;
    logic                 lb_full;
    logic [2:0]           lb_count;
    logic                 lb_wr_valid;
    logic [31:0]          lb_wr_value;
    logic [ROB_TAG_W-1:0] lb_wr_rob_tag;

    load_buffer #(.LB_SIZE(LB_SIZE), .ROB_TAG_W(ROB_TAG_W)) dut (
        .clock(clock), .reset(reset), .lb_push(lb_push), .in_addr(in_addr),
        .in_rob_tag(in_rob_tag), .in_size(in_size), .in_unsigned(in_unsigned),
        .flush(flush), .lb_exec_stall(lb_exec_stall),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .lb_wr_written(lb_wr_written), .lb_read_mem(lb_read_mem),
        .lb_mem_addr(lb_mem_addr), .lb_full(lb_full), .lb_count(lb_count),
        .lb_wr_valid(lb_wr_valid), .lb_wr_value(lb_wr_value),
        .lb_wr_rob_tag(lb_wr_rob_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  tag;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] value;
        logic [3:0]  tag;
    } res_t;

    vec_t vecs [8];
    res_t sb [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, ~a};
    endfunction

    function automatic logic [31:0] ext(input logic [63:0] d, input int off,
                                        input logic [1:0] size, input logic uns);
        logic [31:0] v;
        int nb;
        nb = (size == MEM_BYTE) ? 1 : (size == MEM_HALF) ? 2 : 4;
        v = '0;
        for (int i = 0; i < nb; i++)
            if (off + i < 8) v[8*i +: 8] = d[8*(off+i) +: 8];
        if (!uns && nb < 4 && v[8*nb-1])
            for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
        return v;
    endfunction

    task automatic drive_push(input logic [31:0] a, input logic [3:0] t,
                              input logic [1:0] s, input logic u);
        lb_push = 1'b1; in_addr = a; in_rob_tag = t; in_size = s; in_unsigned = u;
    endtask

    function automatic res_t expect_of(input logic [31:0] a, input logic [3:0] t,
                                       input logic [1:0] s, input logic u);
        res_t r;
        r.value = ext(model({a[31:3], 3'b000}), int'(a[2:0]), s, u);
        r.tag   = t;
        return r;
    endfunction

    // Memory model answers each read one cycle after issue; writebacks accepted at once.
    task automatic run_responder(input int n, input int budget);
        int          got = 0;
        int          cyc = 0;
        logic        pend = 1'b0;
        logic [31:0] paddr = '0;
        res_t        r;
        lb_wr_written = 1'b1;
        while (got < n && cyc < budget) begin
            if (lb_wr_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_wb actual_tag=%0h required=none", lb_wr_rob_tag);
                end else begin
                    r = sb.pop_front();
                    chk("wb_value", lb_wr_value, r.value);
                    chk("wb_tag", lb_wr_rob_tag, r.tag);
                end
                got++;
            end
            if (pend) begin
                mem_data_valid = 1'b1; mem_data = model(paddr); pend = 1'b0;
            end else begin
                mem_data_valid = 1'b0;
            end
            #1;
            if (lb_read_mem) begin
                pend = 1'b1; paddr = lb_mem_addr;
            end
            tick();
            cyc++;
        end
        mem_data_valid = 1'b0;
        lb_wr_written  = 1'b0;
        if (got < n) begin
            total++; bad++;
            $display("FAIL responder_timeout actual=%0d required=%0d", got, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addrs [4];
        logic [1:0]  sizes [4];
        logic        unss  [4];
        res_t        r;
        res_t        held;

        vecs[0] = '{32'h104,   4'd3, MEM_WORD, 1'b0, 64'hAABBCCDD_11223344, 32'hAABBCCDD};
        vecs[1] = '{32'h7,     4'd1, MEM_BYTE, 1'b0, 64'h80000000_00000000, 32'hFFFFFF80};
        vecs[2] = '{32'h7,     4'd2, MEM_BYTE, 1'b1, 64'h80000000_00000000, 32'h00000080};
        vecs[3] = '{32'h2,     4'd5, MEM_HALF, 1'b0, 64'h00000000_87651234, 32'hFFFF8765};
        vecs[4] = '{32'h6,     4'd6, MEM_HALF, 1'b1, 64'hF00D0000_00000000, 32'h0000F00D};
        vecs[5] = '{32'h0,     4'd7, MEM_WORD, 1'b0, 64'h00000000_80000001, 32'h80000001};
        vecs[6] = '{32'h3,     4'd8, MEM_BYTE, 1'b0, 64'h00000000_7F000000, 32'h0000007F};
        vecs[7] = '{32'h10005, 4'd9, MEM_BYTE, 1'b1, 64'h0000C300_00000000, 32'h000000C3};

        reset = 1'b0; lb_push = 1'b0; in_addr = '0; in_rob_tag = '0; in_size = '0;
        in_unsigned = 1'b0; flush = 1'b0; lb_exec_stall = 1'b0;
        mem_data_valid = 1'b0; mem_data = '0; lb_wr_written = 1'b0;

        #3;
        chk("rst_read_mem", lb_read_mem, 0);
        chk("rst_full", lb_full, 0);
        chk("rst_count", lb_count, 0);
        chk("rst_wr_valid", lb_wr_valid, 0);
        chk("rst_wr_value", lb_wr_value, 0);
        chk("rst_wr_tag", lb_wr_rob_tag, 0);
        #9 reset = 1'b1;
        tick();

        // Single loads from the table; eight of them wrap the pointers twice.
        for (int i = 0; i < 8; i++) begin
            drive_push(vecs[i].addr, vecs[i].tag, vecs[i].size, vecs[i].uns);
            sb.push_back('{vecs[i].exp, vecs[i].tag});
            tick();
            lb_push = 1'b0;
            #1;
            chk("issue", lb_read_mem, 1);
            chk("mem_addr", lb_mem_addr, {vecs[i].addr[31:3], 3'b000});
            tick();
            mem_data_valid = 1'b1; mem_data = vecs[i].data;
            tick();
            mem_data_valid = 1'b0;
            #1;
            chk("vec_wr_valid", lb_wr_valid, 1);
            r = sb.pop_front();
            chk("vec_value", lb_wr_value, r.value);
            chk("vec_tag", lb_wr_rob_tag, r.tag);
            chk("vec_count", lb_count, 0);
            lb_wr_written = 1'b1;
            tick();
            lb_wr_written = 1'b0;
            #1;
            chk("vec_wr_clear", lb_wr_valid, 0);
        end

        // Fill while stalled, overflow push ignored, then in-order drain.
        addrs = '{32'h1000, 32'h2003, 32'h3006, 32'h4004};
        sizes = '{MEM_WORD, MEM_BYTE, MEM_HALF, MEM_WORD};
        unss  = '{1'b0, 1'b0, 1'b1, 1'b1};
        lb_exec_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_push(addrs[i], 4'(4 + i), sizes[i], unss[i]);
            sb.push_back(expect_of(addrs[i], 4'(4 + i), sizes[i], unss[i]));
            tick();
        end
        lb_push = 1'b0;
        #1;
        chk("full_flag", lb_full, 1);
        chk("full_count", lb_count, 4);
        chk("stall_no_read", lb_read_mem, 0);
        drive_push(32'h5000, 4'd8, MEM_WORD, 1'b0);
        tick();
        lb_push = 1'b0;
        #1;
        chk("overflow_count", lb_count, 4);
        chk("overflow_full", lb_full, 1);
        lb_exec_stall = 1'b0;
        run_responder(4, 100);
        chk("drain_count", lb_count, 0);

        // Flush with a read outstanding: DRAIN discards the late return.
        lb_exec_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(32'h10 * (i + 1), 4'(i + 1), MEM_WORD, 1'b1);
            tick();
        end
        lb_push = 1'b0;
        lb_exec_stall = 1'b0;
        #1;
        chk("flush_pre_issue", lb_read_mem, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_count", lb_count, 0);
        chk("flush_wr_valid", lb_wr_valid, 0);
        drive_push(32'h60, 4'd9, MEM_WORD, 1'b0);
        sb.push_back(expect_of(32'h60, 4'd9, MEM_WORD, 1'b0));
        tick();
        lb_push = 1'b0;
        #1;
        chk("drain_push_count", lb_count, 1);
        chk("drain_no_read", lb_read_mem, 0);
        mem_data_valid = 1'b1; mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_data_valid = 1'b0;
        #1;
        chk("drain_discard", lb_wr_valid, 0);
        chk("drain_keep_count", lb_count, 1);
        run_responder(1, 20);

        // Flush coincident with the return: straight back to IDLE.
        drive_push(32'h80, 4'd12, MEM_WORD, 1'b0);
        tick();
        lb_push = 1'b0;
        #1;
        chk("fmdv_issue", lb_read_mem, 1);
        tick();
        flush = 1'b1; mem_data_valid = 1'b1; mem_data = 64'h1234_5678_9ABC_DEF0;
        tick();
        flush = 1'b0; mem_data_valid = 1'b0;
        #1;
        chk("fmdv_wr_valid", lb_wr_valid, 0);
        chk("fmdv_count", lb_count, 0);
        drive_push(32'h8A, 4'd13, MEM_HALF, 1'b0);
        sb.push_back(expect_of(32'h8A, 4'd13, MEM_HALF, 1'b0));
        tick();
        lb_push = 1'b0;
        #1;
        chk("fmdv_idle_issue", lb_read_mem, 1);
        run_responder(1, 20);

        // Writeback register holds while not accepted.
        held = expect_of(32'h90, 4'd10, MEM_WORD, 1'b0);
        drive_push(32'h90, 4'd10, MEM_WORD, 1'b0);
        tick();
        lb_push = 1'b0;
        #1;
        chk("hold_issue", lb_read_mem, 1);
        tick();
        mem_data_valid = 1'b1; mem_data = model(32'h90);
        tick();
        mem_data_valid = 1'b0;
        lb_exec_stall = 1'b1;
        drive_push(32'h99, 4'd11, MEM_BYTE, 1'b0);
        sb.push_back(expect_of(32'h99, 4'd11, MEM_BYTE, 1'b0));
        tick();
        lb_push = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_valid", lb_wr_valid, 1);
            chk("hold_value", lb_wr_value, held.value);
            chk("hold_tag", lb_wr_rob_tag, held.tag);
            chk("hold_no_read", lb_read_mem, 0);
            tick();
        end
        lb_wr_written = 1'b1;
        tick();
        lb_wr_written = 1'b0;
        #1;
        chk("hold_release", lb_wr_valid, 0);
        lb_exec_stall = 1'b0;
        run_responder(1, 20);

        // Reset while a read is outstanding.
        drive_push(32'hA0, 4'd14, MEM_WORD, 1'b0);
        tick();
        lb_push = 1'b0;
        #1;
        chk("rmid_issue", lb_read_mem, 1);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rmid_read_mem", lb_read_mem, 0);
        chk("rmid_mem_addr", lb_mem_addr, 0);
        chk("rmid_full", lb_full, 0);
        chk("rmid_count", lb_count, 0);
        chk("rmid_wr_valid", lb_wr_valid, 0);
        chk("rmid_wr_value", lb_wr_value, 0);
        chk("rmid_wr_tag", lb_wr_rob_tag, 0);
        reset = 1'b1;
        tick();
        mem_data_valid = 1'b1; mem_data = model(32'hA0);
        tick();
        mem_data_valid = 1'b0;
        #1;
        chk("rmid_no_wb", lb_wr_valid, 0);
        chk("rmid_count_after", lb_count, 0);
        drive_push(32'hB4, 4'd15, MEM_WORD, 1'b1);
        sb.push_back(expect_of(32'hB4, 4'd15, MEM_WORD, 1'b1));
        tick();
        lb_push = 1'b0;
        #1;
        chk("rmid_idle_issue", lb_read_mem, 1);
        run_responder(1, 20);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
